// File: rtl/sound_event_timer.sv
// Multi-channel sound event timer: latches requests, plays lowest pending channel, then gaps.
// Optional SOUND_RETRIGGER_EN lets a lower-index pending channel preempt the playing one.
module sound_event_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int PLAY_TICKS = 10,
  parameter int GAP_TICKS  = 2,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              tick,
  input  logic [NUM_CH-1:0] soundReq,
  input  logic              mute,
  output logic              playing,
  output logic [SEL_W-1:0]  chSel,
  output logic [CNT_W-1:0]  count,
  output logic              finishCount,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(PLAY_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  =
    CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam bit HAS_GAP = (GAP_TICKS > 0);

  state_t            state;
  logic [SEL_W-1:0]  lowIdx;
  logic              anyPend;
  logic              startOk;
  logic              preempt;
  logic              grant;
  logic [NUM_CH-1:0] grantMask;
  logic [NUM_CH-1:0] clrMask;

  // Priority encoder: lowest set pending bit wins
  always_comb begin
    lowIdx  = '0;
    anyPend = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lowIdx  = SEL_W'(i);
        anyPend = 1'b1;
      end
    end
  end

  assign startOk = (state == IDLE) && anyPend && !mute;

`ifdef SOUND_RETRIGGER_EN
  assign preempt = (state == PLAY) && anyPend && !mute
                && (lowIdx < chSel);
`else
  assign preempt = 1'b0;
`endif

  assign grant     = startOk || preempt;
  assign grantMask = grant ? (NUM_CH'(1) << lowIdx) : '0;
  assign clrMask   = mute ? '1 : grantMask;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      playing     <= 1'b0;
      chSel       <= '0;
      count       <= '0;
      finishCount <= 1'b0;
      pending     <= '0;
    end else begin
      finishCount <= 1'b0;
      // New requests override any clear in the same cycle
      pending     <= (pending & ~clrMask) | soundReq;
      unique case (state)
        IDLE: begin
          count <= '0;
          if (startOk) begin
            state   <= PLAY;
            playing <= 1'b1;
            chSel   <= lowIdx;
          end
        end
        PLAY: begin
          if (mute) begin
            state   <= IDLE;
            playing <= 1'b0;
            count   <= '0;
          end else if (preempt) begin
            chSel <= lowIdx;
            count <= '0;
          end else if (tick) begin
            if (count == PLAY_LAST) begin
              state       <= HAS_GAP ? GAP : IDLE;
              playing     <= 1'b0;
              finishCount <= 1'b1;
              count       <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (mute) begin
            state <= IDLE;
            count <= '0;
          end else if (tick) begin
            if (count == GAP_LAST) begin
              state <= IDLE;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
          count   <= '0;
        end
      endcase
    end
  end

endmodule
